// File: rtl/clock_control.sv
// Front-panel clock controller: debounces the three panel buttons, keeps the manual-mode and
// halt state, and shapes manual step presses into fixed-width step-clock pulses.
module clock_control #(
  parameter int unsigned DEBOUNCE_CYCLES   = 32'h3FFFF,
  parameter int unsigned STEP_PULSE_CYCLES = 32'hFFFFF
) (
  input  logic i_SYS_CLOCK,
  input  logic i_RESET_n,
  input  logic i_BTN_STEP_MODE,
  input  logic i_BTN_STEP,
  input  logic i_BTN_RUN,
  input  logic i_CPU_HALT,
  output logic o_STEP_TOGGLE,
  output logic o_STEP_CLOCK,
  output logic o_HALT,
  output logic o_MANUAL
);

  localparam int unsigned NumBtn  = 3;
  localparam int unsigned BtnMode = 0;
  localparam int unsigned BtnStep = 1;
  localparam int unsigned BtnRun  = 2;

  localparam logic [31:0] DebLast   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] PulseLast = 32'(STEP_PULSE_CYCLES - 1);

  typedef enum logic {StIdle, StHigh} step_state_e;

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] btn_evt;

  assign btn_raw = {i_BTN_RUN, i_BTN_STEP, i_BTN_STEP_MODE};

  for (genvar g = 0; g < NumBtn; g++) begin : gen_btn
    logic        sync1_q;
    logic        sync2_q;
    logic        deb_q;
    logic        deb_prev_q;
    logic [31:0] cnt_q;

    always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= btn_raw[g];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        // Any cycle where the input agrees with the debounced state restarts the count.
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DebLast) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end

    assign btn_evt[g] = deb_q & ~deb_prev_q;
  end

  step_state_e state_q;
  logic [31:0] pulse_cnt_q;
  logic        toggle_q;
  logic        manual_q;
  logic        halt_q;

  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q     <= StIdle;
      pulse_cnt_q <= '0;
      toggle_q    <= 1'b0;
      manual_q    <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      toggle_q <= btn_evt[BtnMode];
      if (btn_evt[BtnMode]) begin
        manual_q <= ~manual_q;
      end

      // A halt request beats a simultaneous RUN press.
      if (i_CPU_HALT) begin
        halt_q <= 1'b1;
      end else if (btn_evt[BtnRun]) begin
        halt_q <= 1'b0;
      end

      // Step qualification uses the pre-toggle manual state; a running pulse is never cut short.
      case (state_q)
        StIdle: begin
          if (btn_evt[BtnStep] && manual_q && !halt_q) begin
            state_q     <= StHigh;
            pulse_cnt_q <= '0;
          end
        end
        StHigh: begin
          if (pulse_cnt_q == PulseLast) begin
            state_q <= StIdle;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_STEP_TOGGLE = toggle_q;
  assign o_STEP_CLOCK  = (state_q == StHigh);
  assign o_HALT        = halt_q;
  assign o_MANUAL      = manual_q;

endmodule

// File: doc/clock_control.md
# clock_control

Front-panel controller that drives the clock generator's control inputs: halt, manual-step toggle and step clock. It synchronises and debounces three raw push-buttons, turns presses into clean single events, shapes manual step presses into fixed-width step-clock pulses, and holds a halt latch that the CPU control unit sets and the RUN button clears. It sits between the board buttons/control unit and the clock generator, all in the `i_SYS_CLOCK` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 32'h3FFFF: consecutive stable cycles required before a button's debounced state changes; must be ≥1.
- `STEP_PULSE_CYCLES`, default 32'hFFFFF: high time of `o_STEP_CLOCK`, in `i_SYS_CLOCK` cycles; must be ≥1.
- `i_SYS_CLOCK` in 1: system clock; every flop is clocked on its rising edge.
- `i_RESET_n` in 1: reset, asynchronous assert, active-low.
- `i_BTN_STEP_MODE` in 1: raw button, active-high, asynchronous; each press toggles manual mode.
- `i_BTN_STEP` in 1: raw button, active-high, asynchronous; each press requests one step.
- `i_BTN_RUN` in 1: raw button, active-high, asynchronous; each press clears halt.
- `i_CPU_HALT` in 1: synchronous halt request from the control unit; sampled every cycle.
- `o_STEP_TOGGLE` out 1: one-cycle pulse per debounced STEP_MODE press; feeds the clock generator's step-toggle input.
- `o_STEP_CLOCK` out 1: step pulse, high for exactly `STEP_PULSE_CYCLES` cycles.
- `o_HALT` out 1: halt level.
- `o_MANUAL` out 1: local mirror of manual-step mode, for the front-panel LED.

## Operation
- Per button, the input path is:
  - Two-flop synchroniser.
  - Debouncer, with a 32-bit counter and a debounced state bit. When the synchroniser output differs from the debounced state, the counter increments. When they match, the counter clears.
  - When the counter has counted `DEBOUNCE_CYCLES` consecutive differing cycles, the debounced state flips and the counter clears. Any bounce shorter than that restarts the count.
  - Registered rising-edge detect on the debounced state produces a one-cycle event. Releases produce no event.
- Mode event:
  - `o_STEP_TOGGLE` is high for that cycle.
  - `o_MANUAL` inverts on the same edge that raises `o_STEP_TOGGLE`.
- Step FSM has two states, IDLE and HIGH. `o_STEP_CLOCK` = (state == HIGH).
  - IDLE → HIGH on a step event when `o_MANUAL`=1 and `o_HALT`=0 in that cycle. Otherwise the event is discarded.
  - HIGH: a 32-bit counter counts `STEP_PULSE_CYCLES` cycles, then the FSM returns to IDLE.
  - Step events arriving while in HIGH are discarded, not queued.
  - A pulse in progress always completes. A mode toggle or halt does not truncate it.
- Halt latch:
  - Set when `i_CPU_HALT`=1 in a cycle.
  - Cleared on a RUN event.
  - If set and clear occur in the same cycle, set wins.
  - A RUN event while not halted has no effect.
- Buttons are independent. Simultaneous events on different buttons are all processed in the same cycle.
  - Mode and step events in the same cycle: the step event is qualified with the pre-toggle `o_MANUAL`.

## Timing
- Reset (`i_RESET_n`=0) immediately clears all of the following:
  - Outputs: `o_STEP_TOGGLE`=0, `o_STEP_CLOCK`=0, `o_HALT`=0, `o_MANUAL`=0.
  - Internal state: synchronisers, debounced states and counters all 0; FSM in IDLE.
- Reset mid-pulse drops `o_STEP_CLOCK` asynchronously.
- A button held through reset release is seen as a new press and produces an event after the normal latency.
- Press latency (D = `DEBOUNCE_CYCLES`): raw input rises and is stable before edge 1.
  - Synchroniser output is 1 from edge 2.
  - Debounced state is 1 from edge D+2.
  - The event and the resulting output change (`o_STEP_TOGGLE`, `o_MANUAL`, start of `o_STEP_CLOCK`, or `o_HALT` clear) take effect at edge D+3.
- `o_STEP_CLOCK` rises at edge N and falls at edge N+`STEP_PULSE_CYCLES`.
- `i_CPU_HALT` high before edge N → `o_HALT`=1 from edge N (one-cycle latency). A step event at edge N is evaluated against `o_HALT` before edge N, so it is accepted.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `STEP_PULSE_CYCLES`=3.
- Reset and mode press:
  - Hold reset, then release; all outputs are 0.
  - Press STEP_MODE (stable from edge 1) → `o_STEP_TOGGLE` high for exactly one cycle after edge 7, `o_MANUAL`=1. A second press returns `o_MANUAL` to 0.
- Bounce rejection: STEP input toggling 1/0 every 2 cycles for 20 cycles, then stable 1 → exactly one step pulse, starting 7 edges after the input becomes stable (`o_MANUAL`=1).
- Step gating:
  - With `o_MANUAL`=0, a step press gives no pulse.
  - With `o_MANUAL`=1, a step press gives `o_STEP_CLOCK` high for exactly 3 cycles.
  - With `o_MANUAL`=1 and `o_HALT`=1, a step press gives no pulse.
- Halt and run:
  - `i_CPU_HALT` pulsed for 1 cycle → `o_HALT`=1 next edge, and it stays 1.
  - A RUN press clears it at edge D+3.
  - RUN event coinciding with `i_CPU_HALT`=1 → `o_HALT` stays 1.
- Pulse integrity:
  - Toggle mode and assert `i_CPU_HALT` while `o_STEP_CLOCK` is high → the pulse still lasts 3 cycles.
  - A second step event during the pulse gives no extra pulse.
- Reset mid-operation: assert `i_RESET_n`=0 during cycle 2 of a step pulse → `o_STEP_CLOCK` falls without waiting for a clock edge. With STEP held through reset release, one pulse follows at release+7 edges only if manual mode has been re-entered; otherwise there is none.
